// File: rtl/alarm_tone_sequencer.sv
// Alarm tone sequencer: per-zone square-wave beep/gap patterns on one piezo pin with
// higher-zone pre-emption. Optional macro ALARM_LATCH_EN adds a HOLD/repeat state and ack.
module alarm_tone_sequencer #(
  parameter logic [11:0] DIV_Z1   = 12'd50,
  parameter logic [11:0] DIV_Z2   = 12'd35,
  parameter logic [11:0] DIV_Z3   = 12'd25,
  parameter logic [15:0] BEEP_LEN = 16'd2000,
  parameter logic [15:0] GAP_LEN  = 16'd1000,
  parameter logic [3:0]  REPEATS  = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] zone_req,
  input  logic       ack,
  output logic       tone_out,
  output logic       tone_active,
  output logic [1:0] zone_latched,
  output logic [7:0] alarm_count
);

  // state | meaning
  // IDLE  | silent, waiting for a request edge
  // BEEP  | tone toggling at the latched zone's pitch
  // GAP   | silence between beeps
  // HOLD  | pattern finished, silent pause before repeating (latching build only)
  typedef enum logic [1:0] {IDLE, BEEP, GAP, HOLD} state_t;

  state_t      state, state_n;
  logic [2:0]  req_prev;
  logic [3:0]  beep_idx, beep_n;
  logic [15:0] dur_cnt, dur_n;
  logic [11:0] div_cnt, div_n, div_lim;
  logic        tone_n;
  logic [1:0]  zone_n, cand;
  logic [7:0]  count_n;
  logic [2:0]  rise;
  logic        accept;

  assign rise = zone_req & ~req_prev;

  always_comb begin
    cand = 2'd0;
    if (rise[2])      cand = 2'd3;
    else if (rise[1]) cand = 2'd2;
    else if (rise[0]) cand = 2'd1;
  end

  assign accept = (cand != 2'd0) && ((state == IDLE) || (cand > zone_latched));

  always_comb begin
    case (zone_latched)
      2'd2:    div_lim = DIV_Z2 - 12'd1;
      2'd3:    div_lim = DIV_Z3 - 12'd1;
      default: div_lim = DIV_Z1 - 12'd1;
    endcase
  end

  always_comb begin
    state_n = state;
    zone_n  = zone_latched;
    count_n = alarm_count;
    beep_n  = beep_idx;
    dur_n   = dur_cnt;
    div_n   = div_cnt;
    tone_n  = tone_out;

    case (state)
      BEEP: begin
        if (dur_cnt == BEEP_LEN - 16'd1) begin
          state_n = GAP;
          tone_n  = 1'b0;
          dur_n   = 16'd0;
          beep_n  = beep_idx + 4'd1;
        end else begin
          dur_n = dur_cnt + 16'd1;
          if (div_cnt == div_lim) begin
            tone_n = ~tone_out;
            div_n  = 12'd0;
          end else begin
            div_n = div_cnt + 12'd1;
          end
        end
      end
      GAP: begin
        tone_n = 1'b0;
        if (dur_cnt == GAP_LEN - 16'd1) begin
          dur_n = 16'd0;
          if (beep_idx < REPEATS) begin
            state_n = BEEP;
            tone_n  = 1'b1;
            div_n   = 12'd0;
          end else begin
`ifdef ALARM_LATCH_EN
            state_n = HOLD;
`else
            state_n = IDLE;
            zone_n  = 2'd0;
`endif
          end
        end else begin
          dur_n = dur_cnt + 16'd1;
        end
      end
`ifdef ALARM_LATCH_EN
      HOLD: begin
        tone_n = 1'b0;
        if (dur_cnt == GAP_LEN - 16'd1) begin
          state_n = BEEP;
          dur_n   = 16'd0;
          beep_n  = 4'd0;
          div_n   = 12'd0;
          tone_n  = 1'b1;
        end else begin
          dur_n = dur_cnt + 16'd1;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        tone_n  = 1'b0;
      end
    endcase

    if (accept) begin
      state_n = BEEP;
      zone_n  = cand;
      count_n = (alarm_count == 8'hFF) ? alarm_count : alarm_count + 8'd1;
      beep_n  = 4'd0;
      dur_n   = 16'd0;
      div_n   = 12'd0;
      tone_n  = 1'b1;
    end

`ifdef ALARM_LATCH_EN
    // Acknowledge overrides a same-cycle accept; the overridden event is not counted.
    if (ack && (state != IDLE)) begin
      state_n = IDLE;
      zone_n  = 2'd0;
      count_n = alarm_count;
      beep_n  = 4'd0;
      dur_n   = 16'd0;
      div_n   = 12'd0;
      tone_n  = 1'b0;
    end
`endif
  end

`ifndef ALARM_LATCH_EN
  logic unused_ack;
  assign unused_ack = ack;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_prev     <= 3'd0;
      zone_latched <= 2'd0;
      alarm_count  <= 8'd0;
      beep_idx     <= 4'd0;
      dur_cnt      <= 16'd0;
      div_cnt      <= 12'd0;
      tone_out     <= 1'b0;
      tone_active  <= 1'b0;
    end else if (ena) begin
      state        <= state_n;
      req_prev     <= zone_req;
      zone_latched <= zone_n;
      alarm_count  <= count_n;
      beep_idx     <= beep_n;
      dur_cnt      <= dur_n;
      div_cnt      <= div_n;
      tone_out     <= tone_n;
      tone_active  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// Self-checking bench for alarm_tone_sequencer with small timing parameters.
// Expectations come from a closed-form beep/gap pattern; ALARM_LATCH_EN selects the latching variant.
module tb_alarm_tone_sequencer;

  localparam int B   = 8;
  localparam int G   = 4;
  localparam int R   = 2;
  localparam int PAT = R * (B + G);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [2:0] zone_req = 3'd0;
  logic       ack = 1'b0;
  logic       tone_out, tone_active;
  logic [1:0] zone_latched;
  logic [7:0] alarm_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    logic       tone;
    logic       act;
    logic [1:0] zone;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic       ack;
    logic       tone;
    logic       act;
    logic [1:0] zone;
    logic [7:0] cnt;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[28];

  alarm_tone_sequencer #(
    .DIV_Z1(12'd2), .DIV_Z2(12'd3), .DIV_Z3(12'd4),
    .BEEP_LEN(16'd8), .GAP_LEN(16'd4), .REPEATS(4'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .zone_req(zone_req), .ack(ack),
    .tone_out(tone_out), .tone_active(tone_active),
    .zone_latched(zone_latched), .alarm_count(alarm_count)
  );

  always #5 clk = ~clk;

  // k = number of edges since the accepting edge (k=0 sampled right after it)
  function automatic logic e_active(input int k);
`ifdef ALARM_LATCH_EN
    return 1'b1;
`else
    return logic'(k < PAT);
`endif
  endfunction

  function automatic logic e_tone(input int k, input int d);
    int kk;
    int p;
    kk = k;
`ifdef ALARM_LATCH_EN
    kk = k % (PAT + G);
`endif
    if (kk >= PAT) return 1'b0;
    p = kk % (B + G);
    if (p >= B) return 1'b0;
    return logic'(((p / d) % 2) == 0);
  endfunction

  task automatic compare(input exp_t e, input string nm);
    checks++;
    if (tone_out !== e.tone || tone_active !== e.act ||
        zone_latched !== e.zone || alarm_count !== e.cnt) begin
      errors++;
      $display("FAIL %s: got tone=%b act=%b zone=%0d cnt=%0d, expected tone=%b act=%b zone=%0d cnt=%0d",
               nm, tone_out, tone_active, zone_latched, alarm_count,
               e.tone, e.act, e.zone, e.cnt);
    end
  endtask

  task automatic step(input logic [2:0] req, input logic a, input logic e,
                      input logic et, input logic ea, input logic [1:0] ez,
                      input logic [7:0] ec, input string nm);
    exp_t x;
    zone_req = req;
    ack = a;
    ena = e;
    exp_q.push_back('{tone: et, act: ea, zone: ez, cnt: ec});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    compare(x, nm);
  endtask

  task automatic run_pat(input logic [2:0] req, input logic [1:0] zone, input int d,
                         input int k0, input int k1, input string nm);
    for (int k = k0; k <= k1; k++) begin
      logic a;
      a = e_active(k);
      step(req, 1'b0, 1'b1, e_tone(k, d), a, a ? zone : 2'd0, 8'(exp_cnt), nm);
    end
  endtask

  task automatic clear_alarm();
    step(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'(exp_cnt), "clear");
    ack = 1'b0;
  endtask

  function automatic int bump(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  initial begin
    for (int i = 0; i < 28; i++) begin
      tbl[i].req  = 3'b001;
      tbl[i].ack  = 1'b0;
`ifndef ALARM_LATCH_EN
      if (i == 5 || i == 6 || i == 25) tbl[i].ack = 1'b1;
`endif
      tbl[i].act  = e_active(i);
      tbl[i].tone = e_tone(i, 2);
      tbl[i].zone = tbl[i].act ? 2'd1 : 2'd0;
      tbl[i].cnt  = 8'd1;
    end

    #2;
    compare('{tone: 1'b0, act: 1'b0, zone: 2'd0, cnt: 8'd0}, "reset_state");
    #10 rst_n = 1'b1;
    step(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, "idle_after_reset");

    // basic zone-1 pattern, request held high throughout
    exp_cnt = 1;
    for (int i = 0; i < 28; i++)
      step(tbl[i].req, tbl[i].ack, 1'b1, tbl[i].tone, tbl[i].act, tbl[i].zone,
           tbl[i].cnt, "basic_pattern");
    run_pat(3'b001, 2'd1, 2, 28, 29, "hold_restart");
    clear_alarm();

    // zone-2 pattern pre-empted by 111 in cycle 10
    exp_cnt = bump(exp_cnt);
    run_pat(3'b010, 2'd2, 3, 0, 9, "zone2_pattern");
    exp_cnt = bump(exp_cnt);
    run_pat(3'b111, 2'd3, 4, 0, 24, "preempt_zone3");
    clear_alarm();

    // lower zone rise during zone-3 pattern is ignored
    exp_cnt = bump(exp_cnt);
    run_pat(3'b100, 2'd3, 4, 0, 4, "zone3_pattern");
    run_pat(3'b101, 2'd3, 4, 5, 24, "ignored_zone1");
    clear_alarm();

    // saturation: zone1 accept then zone3 pre-empt, repeated
    for (int it = 0; it < 150; it++) begin
      int n;
      zone_req = 3'b001; ack = 1'b0;
      @(posedge clk); #1;
      exp_cnt = bump(exp_cnt);
      zone_req = 3'b101;
      @(posedge clk); #1;
      exp_cnt = bump(exp_cnt);
      zone_req = 3'b000;
`ifdef ALARM_LATCH_EN
      ack = 1'b1;
`endif
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (tone_active && n < 40);
      ack = 1'b0;
      checks++;
      if (tone_active !== 1'b0 || alarm_count !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL saturation it=%0d: got act=%b cnt=%0d, expected act=0 cnt=%0d",
                 it, tone_active, alarm_count, exp_cnt);
      end
    end

    // reset mid-BEEP acts without a clock edge
    run_pat(3'b001, 2'd1, 2, 0, 3, "saturated_pattern");
    rst_n = 1'b0;
    #2;
    compare('{tone: 1'b0, act: 1'b0, zone: 2'd0, cnt: 8'd0}, "async_reset");
    zone_req = 3'b001;
    @(negedge clk);
    rst_n = 1'b1;

    // request high across reset release is a rising edge; freeze 5 cycles mid-GAP
    exp_cnt = 1;
    run_pat(3'b001, 2'd1, 2, 0, 9, "post_reset_pattern");
    for (int i = 0; i < 5; i++)
      step(3'b001, 1'b0, 1'b0, e_tone(9, 2), e_active(9), 2'd1, 8'(exp_cnt), "ena_freeze");
    run_pat(3'b001, 2'd1, 2, 10, 24, "ena_resume");
    clear_alarm();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1);
  end

endmodule
